// File: rtl/spw_mem_writer_pkg.sv
// Shared constants, FSM state type and byteenable helper for the SpaceWire byte-to-memory writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spw_mem_writer_pkg;

    localparam int ADDR_WIDTH = 18;
    localparam int MEM_DEPTH  = 217088;
    localparam int LEN_WIDTH  = 20;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        DONE,
        ABORT
    } t_writer_state;

    // Lanes are always filled from lane 0 upward, so the enable is a thermometer code.
    function automatic logic [3:0] lanes_to_byteenable(input logic [2:0] count);
        logic [3:0] be;
        case (count)
            3'd1:    be = 4'b0001;
            3'd2:    be = 4'b0011;
            3'd3:    be = 4'b0111;
            3'd4:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/spw_byte_lane_packer.sv
// Packs bytes little-endian into a 32-bit word; tracks next lane and filled-lane count.
// Latency: byte visible in word the cycle after insert_vld.
// Backpressure: none; the caller must clear before a fifth insert.
module spw_byte_lane_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        insert_vld,
    input  logic [7:0]  insert_dat,
    output logic [1:0]  lane,
    output logic [31:0] word,
    output logic [2:0]  count
);

    // Clear wins over insert so a flushed or discarded word never keeps stale lanes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane  <= 2'd0;
            word  <= 32'd0;
            count <= 3'd0;
        end else if (clear) begin
            lane  <= 2'd0;
            word  <= 32'd0;
            count <= 3'd0;
        end else if (insert_vld) begin
            word[8*lane +: 8] <= insert_dat;
            lane              <= lane + 2'd1;
            count             <= count + 3'd1;
        end
    end

endmodule

// File: rtl/spw_byte_mem_writer.sv
// Avalon-MM write master: packs a byte stream into words written to consecutive memory addresses.
// Latency: one WRITE cycle after the 4th byte (or final byte); 4 bytes per 5 cycles peak.
// Backpressure: snk_ready only in FILL and dropped while cmd_abort is high; cmd_ready only in IDLE.
module spw_byte_mem_writer
    import spw_mem_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_length,
    input  logic                  cmd_abort,
    input  logic [7:0]            snk_data,
    input  logic                  snk_valid,
    output logic                  snk_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    output logic                  mem_clken,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  err_addr,
    output logic                  err_wrap,
    output logic [LEN_WIDTH-1:0]  bytes_written
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    t_writer_state         state;
    t_writer_state         state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  byte_count;
    logic                  err_addr_q;

    logic                  cmd_accept;
    logic                  cmd_bad;
    logic                  byte_accept;
    logic                  last_byte;
    logic                  pk_clear;
    logic [1:0]            pk_lane;
    logic [31:0]           pk_word;
    logic [2:0]            pk_count;

    assign cmd_accept  = (state == IDLE) && cmd_valid;
    assign cmd_bad     = cmd_base_addr > LAST_ADDR;
    assign byte_accept = snk_valid && snk_ready;
    assign last_byte   = (byte_count + LEN_WIDTH'(1)) == len_q;
    // The lane buffer empties after every write and is dropped on an abort out of FILL.
    assign pk_clear    = (state == WRITE) || ((state == FILL) && cmd_abort);

    spw_byte_lane_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .insert_vld (byte_accept),
        .insert_dat (snk_data),
        .lane       (pk_lane),
        .word       (pk_word),
        .count      (pk_count)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and handshake/status decode; abort beats completion except for the write in flight.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        snk_ready = 1'b0;
        mem_write = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        aborted   = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid && !cmd_bad) begin
                    state_nxt = (cmd_length == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                snk_ready = !cmd_abort;
                if (cmd_abort) begin
                    state_nxt = ABORT;
                end else if (snk_valid && ((pk_lane == 2'd3) || last_byte)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                if (cmd_abort)                 state_nxt = ABORT;
                else if (byte_count == len_q)  state_nxt = DONE;
                else                           state_nxt = FILL;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ABORT: begin
                aborted   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, byte/commit counters, address advance with wrap, and error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q        <= '0;
            len_q         <= '0;
            byte_count    <= '0;
            bytes_written <= '0;
            err_wrap      <= 1'b0;
            err_addr_q    <= 1'b0;
        end else begin
            err_addr_q <= 1'b0;
            if (cmd_accept) begin
                err_wrap <= 1'b0;
                if (cmd_bad) begin
                    err_addr_q <= 1'b1;
                end else begin
                    addr_q        <= cmd_base_addr;
                    len_q         <= cmd_length;
                    byte_count    <= '0;
                    bytes_written <= '0;
                end
            end
            if (byte_accept) begin
                byte_count <= byte_count + LEN_WIDTH'(1);
            end
            if (state == WRITE) begin
                bytes_written <= bytes_written + LEN_WIDTH'(pk_count);
                if (addr_q == LAST_ADDR) begin
                    addr_q   <= '0;
                    err_wrap <= 1'b1;
                end else begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign err_addr       = err_addr_q;
    assign mem_clken      = 1'b1;
    assign mem_chipselect = mem_write;
    assign mem_address    = mem_write ? addr_q : '0;
    assign mem_writedata  = mem_write ? pk_word : 32'd0;
    assign mem_byteenable = mem_write ? lanes_to_byteenable(pk_count) : 4'd0;

endmodule

// File: tb/tb_spw_byte_mem_writer.sv
// Self-checking bench for spw_byte_mem_writer: vector table plus directed timing sequences.
// Latency: n/a.
// Backpressure: bench waits on snk_ready with a bounded cycle budget.
module tb_spw_byte_mem_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [17:0] cmd_base_addr = '0;
    logic [19:0] cmd_length = '0;
    logic        cmd_abort = 1'b0;
    logic [7:0]  snk_data = '0;
    logic        snk_valid = 1'b0;
    logic        snk_ready;
    logic [17:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        err_addr;
    logic        err_wrap;
    logic [19:0] bytes_written;

    spw_byte_mem_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_base_addr  (cmd_base_addr),
        .cmd_length     (cmd_length),
        .cmd_abort      (cmd_abort),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .err_addr       (err_addr),
        .err_wrap       (err_wrap),
        .bytes_written  (bytes_written)
    );

    always #5 clk = ~clk;

    // Write log and pulse counters, sampled mid-cycle.
    logic [17:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [3:0]  wr_be   [64];
    logic        wr_cs   [64];
    int          wr_n = 0;
    int          done_n = 0;
    int          abort_n = 0;
    int          erra_n = 0;

    always @(negedge clk) begin
        if (mem_write) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] <= mem_address;
                wr_data[wr_n] <= mem_writedata;
                wr_be[wr_n]   <= mem_byteenable;
                wr_cs[wr_n]   <= mem_chipselect;
            end
            wr_n <= wr_n + 1;
        end
        done_n  <= done_n + int'(done);
        abort_n <= abort_n + int'(aborted);
        erra_n  <= erra_n + int'(err_addr);
    end

    int pass_n = 0;
    int total_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [17:0] base;
        logic [19:0] len;
        logic [7:0]  first;
        logic [7:0]  step;
        int          abort_after;
        int          nw;
        logic [17:0] a0;
        logic [31:0] d0;
        logic [3:0]  b0;
        logic [17:0] al;
        logic [31:0] dl;
        logic [3:0]  bl;
        int          n_done;
        int          n_abort;
        int          n_err;
        logic [19:0] bw;
        logic        wrap;
    } vec_t;

    vec_t vecs [8];

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic feed_byte(input logic [7:0] d, input string tag);
        bit ok;
        ok = 1'b0;
        snk_data  = d;
        snk_valid = 1'b1;
        for (int g = 0; g < 20 && !ok; g++) begin
            #1;
            if (snk_ready) ok = 1'b1;
            @(negedge clk);
        end
        chk({tag, ".byte_taken"}, 32'(ok), 32'd1);
    endtask

    task automatic send_cmd(input logic [17:0] base, input logic [19:0] len);
        cmd_valid     = 1'b1;
        cmd_base_addr = base;
        cmd_length    = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s_w, s_d, s_a, s_e, nw;
        logic [7:0] b;
        s_w = wr_n; s_d = done_n; s_a = abort_n; s_e = erra_n;
        send_cmd(v.base, v.len);
        b = v.first;
        if (v.n_err == 0) begin
            for (int i = 0; i < int'(v.len); i++) begin
                if (i == v.abort_after) begin
                    snk_valid = 1'b0;
                    cmd_abort = 1'b1;
                    @(negedge clk);
                    cmd_abort = 1'b0;
                    break;
                end
                feed_byte(b, tag);
                b = b + v.step;
            end
        end
        snk_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        nw = wr_n - s_w;
        chk({tag, ".writes"}, 32'(nw), 32'(v.nw));
        if (v.nw > 0 && nw > 0 && wr_n <= 64) begin
            chk({tag, ".w0_addr"}, 32'(wr_addr[s_w]), 32'(v.a0));
            chk({tag, ".w0_data"}, wr_data[s_w], v.d0);
            chk({tag, ".w0_be"},   32'(wr_be[s_w]), 32'(v.b0));
            chk({tag, ".w0_cs"},   32'(wr_cs[s_w]), 32'd1);
            chk({tag, ".wl_addr"}, 32'(wr_addr[wr_n-1]), 32'(v.al));
            chk({tag, ".wl_data"}, wr_data[wr_n-1], v.dl);
            chk({tag, ".wl_be"},   32'(wr_be[wr_n-1]), 32'(v.bl));
        end
        chk({tag, ".done_pulses"},  32'(done_n - s_d),  32'(v.n_done));
        chk({tag, ".abort_pulses"}, 32'(abort_n - s_a), 32'(v.n_abort));
        chk({tag, ".erraddr_pulses"}, 32'(erra_n - s_e), 32'(v.n_err));
        chk({tag, ".bytes_written"}, 32'(bytes_written), 32'(v.bw));
        chk({tag, ".err_wrap"}, 32'(err_wrap), 32'(v.wrap));
        chk({tag, ".idle_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int s_w;
        //          base     len   first  step abrt nw a0       d0            b0    al       dl            bl    dn ab er bw  wrap
        vecs[0] = '{18'h10,  20'd8, 8'h11, 8'h11, -1, 2, 18'h10,  32'h44332211, 4'hF, 18'h11,  32'h88776655, 4'hF, 1, 0, 0, 20'd8, 1'b0};
        vecs[1] = '{18'h20,  20'd6, 8'hA1, 8'h01, -1, 2, 18'h20,  32'hA4A3A2A1, 4'hF, 18'h21,  32'h0000A6A5, 4'h3, 1, 0, 0, 20'd6, 1'b0};
        vecs[2] = '{18'd217087, 20'd8, 8'h01, 8'h01, -1, 2, 18'd217087, 32'h04030201, 4'hF, 18'd0, 32'h08070605, 4'hF, 1, 0, 0, 20'd8, 1'b1};
        vecs[3] = '{18'h30,  20'd0, 8'h00, 8'h00, -1, 0, 18'h0,   32'h0,        4'h0, 18'h0,   32'h0,        4'h0, 1, 0, 0, 20'd0, 1'b0};
        vecs[4] = '{18'd217088, 20'd4, 8'h00, 8'h00, -1, 0, 18'h0, 32'h0,       4'h0, 18'h0,   32'h0,        4'h0, 0, 0, 1, 20'd0, 1'b0};
        vecs[5] = '{18'h40,  20'd16, 8'h01, 8'h01, 5, 1, 18'h40,  32'h04030201, 4'hF, 18'h40,  32'h04030201, 4'hF, 0, 1, 0, 20'd4, 1'b0};
        vecs[6] = '{18'h50,  20'd5, 8'hB1, 8'h01, -1, 2, 18'h50,  32'hB4B3B2B1, 4'hF, 18'h51,  32'h000000B5, 4'h1, 1, 0, 0, 20'd5, 1'b0};
        vecs[7] = '{18'h60,  20'd3, 8'hC1, 8'h01, -1, 1, 18'h60,  32'h00C3C2C1, 4'h7, 18'h60,  32'h00C3C2C1, 4'h7, 1, 0, 0, 20'd3, 1'b0};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.mem_clken", 32'(mem_clken), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.snk_ready", 32'(snk_ready), 32'd0);
        chk("rst.mem_write", 32'({mem_write, mem_chipselect, mem_byteenable}), 32'd0);
        chk("rst.pulses", 32'({done, aborted, err_addr, err_wrap}), 32'd0);
        chk("rst.bytes_written", 32'(bytes_written), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero length: done the cycle after acceptance.
        send_cmd(18'h5, 20'd0);
        #1;
        chk("len0.done", 32'({done, busy}), 32'b11);
        @(negedge clk); #1;
        chk("len0.done_end", 32'({done, cmd_ready}), 32'b01);
        @(negedge clk);

        // Out-of-range base: error pulse, ready stays high.
        send_cmd(18'd217088, 20'd4);
        #1;
        chk("badaddr.err", 32'({err_addr, cmd_ready, busy}), 32'b110);
        @(negedge clk); #1;
        chk("badaddr.err_end", 32'(err_addr), 32'd0);
        @(negedge clk);

        // Abort raised during the write cycle: the write still happens.
        s_w = wr_n;
        send_cmd(18'h70, 20'd8);
        feed_byte(8'hD1, "abw"); feed_byte(8'hD2, "abw");
        feed_byte(8'hD3, "abw"); feed_byte(8'hD4, "abw");
        snk_valid = 1'b0;
        cmd_abort = 1'b1;
        #1;
        chk("abw.in_write", 32'({mem_write, snk_ready}), 32'b10);
        chk("abw.addr", 32'(mem_address), 32'h70);
        chk("abw.data", mem_writedata, 32'hD4D3D2D1);
        @(negedge clk);
        cmd_abort = 1'b0;
        #1;
        chk("abw.aborted", 32'({aborted, done}), 32'b10);
        repeat (4) @(negedge clk);
        #2;
        chk("abw.writes", 32'(wr_n - s_w), 32'd1);
        chk("abw.bytes_written", 32'(bytes_written), 32'd4);
        @(negedge clk);

        // Reset during FILL after two bytes.
        s_w = wr_n;
        send_cmd(18'h80, 20'd8);
        feed_byte(8'hE1, "rstfill"); feed_byte(8'hE2, "rstfill");
        snk_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rstfill.state", 32'({cmd_ready, busy, snk_ready, mem_write}), 32'b1000);
        chk("rstfill.bytes_written", 32'(bytes_written), 32'd0);
        chk("rstfill.pulses", 32'({done, aborted}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("rstfill.writes", 32'(wr_n - s_w), 32'd0);
        @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
